// File: rtl/even_odd_count_checker_if.sv
// rtl/even_odd_count_checker_if.sv - observed counter controls/output plus checker results
// Optional EOC_STICKY_ERR_EN adds the sticky_err result line.
interface even_odd_count_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             load;
  logic             mode;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] count;
  logic             locked;
  logic [WIDTH-1:0] exp_count;
  logic             seq_err;
  logic             parity_err;
  logic             mode_err;
  logic [ERR_W-1:0] err_cnt;
`ifdef EOC_STICKY_ERR_EN
  logic             sticky_err;
`endif

  modport master (
    output load, mode, data_in, count,
    input  locked, exp_count, seq_err, parity_err, mode_err, err_cnt
`ifdef EOC_STICKY_ERR_EN
    , input sticky_err
`endif
  );

  modport slave (
    input  load, mode, data_in, count,
    output locked, exp_count, seq_err, parity_err, mode_err, err_cnt
`ifdef EOC_STICKY_ERR_EN
    , output sticky_err
`endif
  );
endinterface

// File: rtl/even_odd_count_checker.sv
// rtl/even_odd_count_checker.sv - predicts the even/odd step counter and flags sequence, parity and mode errors
// Optional EOC_STICKY_ERR_EN: sticky_err output and a terminal FAIL state.
module even_odd_count_checker #(
  parameter int WIDTH = 4,
  parameter int STEP  = 2,
  parameter int ERR_W = 8
) (
  input logic clk,
  input logic rst,
  even_odd_count_checker_if.slave bus
);
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

`ifdef EOC_STICKY_ERR_EN
  typedef enum logic [1:0] {IDLE, ARM, TRACK, FAIL} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARM, TRACK} state_t;
`endif

  state_t           state;
  logic             mode_q;
  logic             cmp_en;
  logic             mode_chg;
  logic             seq_hit;
  logic             par_hit;
  logic             any_err;
  logic [1:0]       n_err;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_next;

  // A mode change without load masks the compare for that cycle.
  always_comb begin
    cmp_en   = (state == ARM) || (state == TRACK);
    mode_chg = cmp_en && !bus.load && (bus.mode != mode_q);
    seq_hit  = cmp_en && !mode_chg && (bus.count != bus.exp_count);
    par_hit  = cmp_en && !mode_chg && (bus.count[0] != mode_q);
    any_err  = seq_hit || par_hit || mode_chg;
    n_err    = {1'b0, seq_hit} + {1'b0, par_hit} + {1'b0, mode_chg};
    err_sum  = {1'b0, bus.err_cnt} + {{(ERR_W - 1){1'b0}}, n_err};
    err_next = err_sum[ERR_W] ? ERR_MAX : err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      mode_q         <= 1'b0;
      bus.locked     <= 1'b0;
      bus.exp_count  <= '0;
      bus.seq_err    <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.mode_err   <= 1'b0;
      bus.err_cnt    <= '0;
`ifdef EOC_STICKY_ERR_EN
      bus.sticky_err <= 1'b0;
`endif
    end else begin
      bus.seq_err    <= seq_hit;
      bus.parity_err <= par_hit;
      bus.mode_err   <= mode_chg;
      bus.err_cnt    <= err_next;
`ifdef EOC_STICKY_ERR_EN
      if (any_err) bus.sticky_err <= 1'b1;
`endif
      case (state)
        IDLE: begin
          bus.locked <= 1'b0;
          if (bus.load) begin
            bus.exp_count <= bus.data_in;
            mode_q        <= bus.mode;
            state         <= ARM;
          end
        end
        ARM, TRACK: begin
          // Predict from the observed count so one bad sample yields one error.
          bus.exp_count <= bus.load ? bus.data_in : bus.count + STEP_V;
`ifdef EOC_STICKY_ERR_EN
          if (any_err) begin
            state      <= FAIL;
            bus.locked <= 1'b0;
          end else
`endif
          if (bus.load) begin
            mode_q     <= bus.mode;
            state      <= ARM;
            bus.locked <= 1'b0;
          end else if (any_err) begin
            state      <= IDLE;
            bus.locked <= 1'b0;
          end else begin
            state      <= TRACK;
            bus.locked <= 1'b1;
          end
        end
        default: begin
          bus.locked <= 1'b0;
`ifndef EOC_STICKY_ERR_EN
          state      <= IDLE;
`endif
        end
      endcase
    end
  end
endmodule
